// File: rtl/noc_pkg.sv
// Shared mesh-router types: flit container, destination address layout, input buffer states.
package noc_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_X_MSB = 7;
  localparam int ADDR_X_LSB = 4;
  localparam int ADDR_Y_MSB = 3;
  localparam int ADDR_Y_LSB = 0;

  typedef logic [DATA_W-1:0] flit_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } node_addr_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } inbuf_state_t;

endpackage

// File: rtl/inbuf_ram.sv
// Flit storage for the router input buffer: one write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owning controller.
module inbuf_ram #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_input_buffer.sv
// Per-port router input FIFO: accepts flits from upstream, presents the head to the controller, pops on grant.
// Optional INBUF_BYPASS_EN: an empty buffer forwards an arriving flit to the head outputs in the same cycle.
//
// state   | meaning
// EMPTY   | count == 0, head outputs gated to zero
// PARTIAL | 0 < count < DEPTH
// FULL    | count == DEPTH, buffer_full_o asserted to upstream
module router_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        flit_i,
  input  logic                     flit_valid_i,
  output logic                     buffer_full_o,
  output logic [7:0]               packet_addr_o,
  output logic                     packet_valid_o,
  output logic [DATA_W-1:0]        flit_o,
  input  logic                     grant_i,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  inbuf_state_t       state, state_nxt;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               overflow;
  logic [DATA_W-1:0]  rd_data, head_raw;
  logic               bypass, push, pop, do_push, do_pop;
  node_addr_t         head_addr;

  inbuf_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (flit_i),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef INBUF_BYPASS_EN
  assign bypass = (state == ST_EMPTY) & flit_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign buffer_full_o  = (state == ST_FULL);
  assign packet_valid_o = (state != ST_EMPTY) | bypass;
  assign head_raw       = bypass ? flit_i : rd_data;
  assign flit_o         = packet_valid_o ? head_raw : '0;
  assign head_addr.x    = flit_o[ADDR_X_MSB:ADDR_X_LSB];
  assign head_addr.y    = flit_o[ADDR_Y_MSB:ADDR_Y_LSB];
  assign packet_addr_o  = head_addr;
  assign overflow_o     = overflow;
  assign count_o        = count;

  // A bypassed flit granted in its arrival cycle never touches the RAM or the pointers.
  assign push    = flit_valid_i & ~buffer_full_o;
  assign pop     = grant_i & packet_valid_o;
  assign do_push = push & ~(bypass & grant_i);
  assign do_pop  = pop & ~bypass;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
    case (state)
      ST_EMPTY:   if (do_push) state_nxt = ST_PARTIAL;
      ST_PARTIAL: begin
        if (do_push && !do_pop && count == CNT_LAST)      state_nxt = ST_FULL;
        else if (do_pop && !do_push && count == CNT_ONE)  state_nxt = ST_EMPTY;
      end
      ST_FULL:    if (do_pop) state_nxt = ST_PARTIAL;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (flit_valid_i && buffer_full_o) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_router_input_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] flit_i;
  logic              flit_valid_i;
  logic              buffer_full_o;
  logic [7:0]        packet_addr_o;
  logic              packet_valid_o;
  logic [DATA_W-1:0] flit_o;
  logic              grant_i;
  logic              overflow_o;
  logic [2:0]        count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  bit          armed = 1'b0;

  router_input_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_i         (flit_i),
    .flit_valid_i   (flit_valid_i),
    .buffer_full_o  (buffer_full_o),
    .packet_addr_o  (packet_addr_o),
    .packet_valid_o (packet_valid_o),
    .flit_o         (flit_o),
    .grant_i        (grant_i),
    .overflow_o     (overflow_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic g);
    bit          byp;
    bit          exp_valid;
    bit          full;
    logic [31:0] exp_head;
    @(negedge clk);
    rst = r; flit_valid_i = v; flit_i = d; grant_i = g;
    #1;
    byp = 1'b0;
`ifdef INBUF_BYPASS_EN
    byp = (q.size() == 0) && v;
`endif
    exp_valid = (q.size() > 0) || byp;
    exp_head  = byp ? d : ((q.size() > 0) ? q[0] : 32'h0);
    full      = (q.size() == DEPTH);
    if (armed) begin
      chk("valid", {31'b0, packet_valid_o}, {31'b0, exp_valid});
      chk("flit",  flit_o, exp_head);
      chk("addr",  {24'b0, packet_addr_o}, {24'b0, exp_head[7:0]});
      chk("full",  {31'b0, buffer_full_o}, {31'b0, full});
      chk("count", {29'b0, count_o}, q.size());
      chk("ovf",   {31'b0, overflow_o}, {31'b0, m_ovf});
    end
    if (!r) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (v && full) m_ovf = 1'b1;
      if (!(byp && g)) begin
        if (g && exp_valid) void'(q.pop_front());
        if (v && !full) q.push_back(d);
      end
    end
    @(posedge clk);
    if (!r) armed = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flit_valid_i = 1'b0; flit_i = '0; grant_i = 1'b0;

    // Reset held two cycles with traffic on the link.
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    chk("rst_count", {29'b0, count_o}, 32'd0);
    chk("rst_valid", {31'b0, packet_valid_o}, 32'd0);
    chk("rst_full",  {31'b0, buffer_full_o}, 32'd0);
    chk("rst_ovf",   {31'b0, overflow_o}, 32'd0);

    // Single flit, head held stable without grant, then granted.
    step(1'b1, 1'b1, 32'h0000_0023, 1'b0);
    #1;
    chk("t2_addr", {24'b0, packet_addr_o}, 32'h23);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("t2_empty", {31'b0, packet_valid_o}, 32'd0);

    // Fill to FULL, overflow attempt, drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h11 + i, 1'b0);
    #1;
    chk("t3_full", {31'b0, buffer_full_o}, 32'd1);
    step(1'b1, 1'b1, 32'h15, 1'b0);
    #1;
    chk("t3_ovf", {31'b0, overflow_o}, 32'd1);
    chk("t3_cnt", {29'b0, count_o}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_head", {24'b0, packet_addr_o}, 32'h11 + i);
      step(1'b1, 1'b0, 32'h0, 1'b1);
    end
    #1;
    chk("t3_drained", {31'b0, packet_valid_o}, 32'd0);

    // Reset clears the sticky overflow, then steady push+pop at count 2 across pointer wraps.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b1, 32'h101, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h102 + i, 1'b1);
    #1;
    chk("t4_cnt", {29'b0, count_o}, 32'd2);
    chk("t4_head", flit_o, 32'h10A);

    // Pop while FULL with valid held: the flit is refused, then the next push lands.
    step(1'b1, 1'b1, 32'h200, 1'b0);
    step(1'b1, 1'b1, 32'h201, 1'b0);
    step(1'b1, 1'b1, 32'h2FF, 1'b1);
    #1;
    chk("t5_cnt",  {29'b0, count_o}, 32'd3);
    chk("t5_full", {31'b0, buffer_full_o}, 32'd0);
    step(1'b1, 1'b1, 32'h202, 1'b0);
    #1;
    chk("t5_cnt2", {29'b0, count_o}, 32'd4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Arrival into an empty buffer with a same-cycle grant.
    step(1'b1, 1'b1, 32'h42, 1'b1);
    #1;
`ifdef INBUF_BYPASS_EN
    chk("t6_cnt", {29'b0, count_o}, 32'd0);
`else
    chk("t6_cnt", {29'b0, count_o}, 32'd1);
    chk("t6_addr", {24'b0, packet_addr_o}, 32'h42);
`endif
    step(1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
